// File: rtl/opm_write_queue.sv
// opm_write_queue: paced {reg,data} write buffer between the host bus and a YM2151/IKAOPM.
// Optional sticky overflow flag on status bit6 when OPM_WRQ_OVF_EN is defined.
module opm_write_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STROBE_CYC = 28,
    parameter int GAP_CYC    = 14,
    parameter int SETTLE_CYC = 56
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slv_addr_i,
    input  logic [7:0] slv_datawr_i,
    input  logic       slv_datawr_valid,
    input  logic       slv_req_i,
    input  logic       slv_rwn_i,
    output logic [7:0] slv_datard_o,
    output logic       opm_cs_n,
    output logic       opm_wr_n,
    output logic       opm_a0,
    output logic [7:0] opm_d,
    input  logic [7:0] opm_status_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, AWR, GAP, DWR, SETTLE, WBUSY} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [15:0]           cur_q, cur_d;
    logic [7:0]            addr_latch_q, addr_latch_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           mem_q [DEPTH];
    logic                  opm_cs_n_q, opm_cs_n_d, opm_wr_n_q, opm_wr_n_d, opm_a0_q, opm_a0_d;
    logic [7:0]            opm_d_q, opm_d_d;
    logic                  wr_ev, push, pop, full, accept, strobe, busy_m;

    always_comb begin
        wr_ev        = slv_req_i & ~slv_rwn_i & slv_datawr_valid;
        push         = wr_ev & slv_addr_i;
        pop          = (state_q == IDLE) & (count_q != '0);
        full         = count_q == (DEPTH_LOG2+1)'(DEPTH);
        // a full FIFO still takes a push when the head leaves in the same clk
        accept       = push & (~full | pop);
        addr_latch_d = (wr_ev & ~slv_addr_i) ? slv_datawr_i : addr_latch_q;
        wr_ptr_d     = wr_ptr_q + DEPTH_LOG2'(accept);
        rd_ptr_d     = rd_ptr_q + DEPTH_LOG2'(pop);
        count_d      = count_q + (DEPTH_LOG2+1)'(accept) - (DEPTH_LOG2+1)'(pop);
        busy_m       = opm_status_i[7] | (count_q != '0) | (state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 8'd1 : cnt_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: if (pop) begin
                cur_d   = mem_q[rd_ptr_q];
                cnt_d   = 8'(STROBE_CYC - 1);
                state_d = AWR;
            end
            AWR: if (cnt_q == '0) begin
                cnt_d   = 8'(GAP_CYC - 1);
                state_d = GAP;
            end
            GAP: if (cnt_q == '0) begin
                cnt_d   = 8'(STROBE_CYC - 1);
                state_d = DWR;
            end
            DWR: if (cnt_q == '0) begin
                cnt_d   = 8'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q == '0) state_d = WBUSY;
            WBUSY: if (!opm_status_i[7]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // strobes derive from the next state so the pins change exactly with the state register
        strobe     = (state_d == AWR) | (state_d == DWR);
        opm_cs_n_d = ~strobe;
        opm_wr_n_d = ~strobe;
        opm_a0_d   = (state_d == DWR) ? 1'b1 : (state_d == AWR) ? 1'b0 : opm_a0_q;
        opm_d_d    = (state_d == AWR) ? cur_d[15:8] : (state_d == DWR) ? cur_d[7:0] : opm_d_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            addr_latch_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            opm_cs_n_q   <= 1'b1;
            opm_wr_n_q   <= 1'b1;
            opm_a0_q     <= 1'b0;
            opm_d_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            addr_latch_q <= addr_latch_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            opm_cs_n_q   <= opm_cs_n_d;
            opm_wr_n_q   <= opm_wr_n_d;
            opm_a0_q     <= opm_a0_d;
            opm_d_q      <= opm_d_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= {addr_latch_q, slv_datawr_i};
    end

    assign opm_cs_n = opm_cs_n_q;
    assign opm_wr_n = opm_wr_n_q;
    assign opm_a0   = opm_a0_q;
    assign opm_d    = opm_d_q;

`ifdef OPM_WRQ_OVF_EN
    logic ovf_q, ovf_d;
    always_comb begin
        ovf_d = (push & ~accept) ? 1'b1 : (slv_req_i & slv_rwn_i & slv_addr_i) ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end
    assign slv_datard_o = {busy_m, ovf_q, opm_status_i[5:0]};
`else
    assign slv_datard_o = {busy_m, opm_status_i[6:0]};
`endif
endmodule
